// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered LSU loads into the registered
// register-file write port and tracks in-flight destinations. Optional forwarding outputs: WB_FWD_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

module wb_arbiter #(
   parameter int LSU_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [`REG_WIDTH-1:0] alu_rd,
   input  logic [`WIDTH-1:0]     alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [`REG_WIDTH-1:0] lsu_rd,
   input  logic [`WIDTH-1:0]     lsu_data,
   input  logic                  iss_valid,
   input  logic [`REG_WIDTH-1:0] iss_rd,
   input  logic [`REG_WIDTH-1:0] raddr1,
   input  logic [`REG_WIDTH-1:0] raddr2,
   output logic                  busy1,
   output logic                  busy2,
   output logic                  wen,
   output logic [`REG_WIDTH-1:0] waddr,
   output logic [`WIDTH-1:0]     wdata,
`ifdef WB_FWD_EN
   output logic                  fwd1,
   output logic                  fwd2,
   output logic [`WIDTH-1:0]     fwd_data1,
   output logic [`WIDTH-1:0]     fwd_data2,
`endif
   output logic                  wb_pending
);

   localparam int W  = `WIDTH;
   localparam int RW = `REG_WIDTH;
   localparam int PW = $clog2(LSU_DEPTH) + 1;
   localparam int AW = PW - 1;

   logic [RW+W-1:0]    mem [LSU_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic [RW+W-1:0]    head;
   logic               sel_valid;
   logic [RW-1:0]      sel_rd;
   logic [W-1:0]       sel_data;
   logic               sel_wr;
   logic [`REG_NUM-1:0] busy;

   assign empty = (wr_ptr == rd_ptr);
   // Same slot but opposite lap bit means the writer is a full lap ahead.
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   assign lsu_ready  = !full;
   assign wb_pending = !empty;
   assign push       = lsu_valid && !full;
   assign pop        = !alu_valid && !empty;
   assign head       = mem[rd_ptr[AW-1:0]];

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (!empty) begin
         sel_valid = 1'b1;
         sel_rd    = head[RW+W-1:W];
         sel_data  = head[W-1:0];
      end
   end

   assign sel_wr = sel_valid && (sel_rd != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {lsu_rd, lsu_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         wen <= sel_wr;
         if (sel_wr) begin
            waddr <= sel_rd;
            wdata <= sel_data;
         end
      end
   end

   // The set is applied last so a re-issue of the retiring register stays busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (sel_wr)                       busy[sel_rd] <= 1'b0;
         if (iss_valid && iss_rd != '0)    busy[iss_rd] <= 1'b1;
      end
   end

   assign busy1 = (raddr1 != '0) && busy[raddr1];
   assign busy2 = (raddr2 != '0) && busy[raddr2];

`ifdef WB_FWD_EN
   assign fwd1      = wen && (waddr == raddr1) && (raddr1 != '0);
   assign fwd2      = wen && (waddr == raddr2) && (raddr2 != '0);
   assign fwd_data1 = wdata;
   assign fwd_data2 = wdata;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based writeback model, plus directed scenarios.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

module tb_wb_arbiter;

   localparam int W  = `WIDTH;
   localparam int RW = `REG_WIDTH;
   localparam int RN = `REG_NUM;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [RW-1:0] alu_rd = '0;
   logic [W-1:0]  alu_data = '0;
   logic          lsu_valid = 1'b0;
   logic          lsu_ready;
   logic [RW-1:0] lsu_rd = '0;
   logic [W-1:0]  lsu_data = '0;
   logic          iss_valid = 1'b0;
   logic [RW-1:0] iss_rd = '0;
   logic [RW-1:0] raddr1 = '0;
   logic [RW-1:0] raddr2 = '0;
   logic          busy1, busy2, wen, wb_pending;
   logic [RW-1:0] waddr;
   logic [W-1:0]  wdata;
`ifdef WB_FWD_EN
   logic          fwd1, fwd2;
   logic [W-1:0]  fwd_data1, fwd_data2;
`endif

   always #5 clk = ~clk;

   wb_arbiter #(.LSU_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
      .wen(wen), .waddr(waddr), .wdata(wdata),
`ifdef WB_FWD_EN
      .fwd1(fwd1), .fwd2(fwd2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
      .wb_pending(wb_pending)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: pending loads as a queue, busy set as a bit array, output triple.
   logic [RW+W-1:0] m_q[$];
   bit              m_busy [RN];
   logic            m_wen;
   logic [RW-1:0]   m_waddr;
   logic [W-1:0]    m_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   task automatic model_step(input logic av, input logic [RW-1:0] ard, input logic [W-1:0] ad,
                             input logic lv, input logic [RW-1:0] lrd, input logic [W-1:0] ld,
                             input logic iv, input logic [RW-1:0] ird, input logic rn);
      logic          sv;
      logic [RW-1:0] srd;
      logic [W-1:0]  sd;
      logic          rdy;
      if (!rn) begin
         model_reset();
         return;
      end
      rdy = (m_q.size() < D);
      sv  = 1'b0;
      srd = '0;
      sd  = '0;
      if (av) begin
         sv = 1'b1; srd = ard; sd = ad;
      end else if (m_q.size() > 0) begin
         sv = 1'b1;
         {srd, sd} = m_q.pop_front();
      end
      if (lv && rdy) m_q.push_back({lrd, ld});
      m_wen = sv && (srd != 0);
      if (m_wen) begin
         m_waddr = srd;
         m_wdata = sd;
         m_busy[srd] = 1'b0;
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
   endtask

   task automatic compare();
      chk("wen", wen, m_wen);
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
      chk("lsu_ready", lsu_ready, m_q.size() < D);
      chk("wb_pending", wb_pending, m_q.size() > 0);
      chk("busy1", busy1, (raddr1 != 0) && m_busy[raddr1]);
      chk("busy2", busy2, (raddr2 != 0) && m_busy[raddr2]);
`ifdef WB_FWD_EN
      chk("fwd1", fwd1, m_wen && (m_waddr == raddr1) && (raddr1 != 0));
      chk("fwd2", fwd2, m_wen && (m_waddr == raddr2) && (raddr2 != 0));
      chk("fwd_data1", fwd_data1, m_wdata);
      chk("fwd_data2", fwd_data2, m_wdata);
`endif
   endtask

   // One cycle: drive at negedge, compare just after, then advance the model to the next posedge.
   task automatic drive(input logic av, input logic [RW-1:0] ard, input logic [W-1:0] ad,
                        input logic lv, input logic [RW-1:0] lrd, input logic [W-1:0] ld,
                        input logic iv, input logic [RW-1:0] ird,
                        input logic [RW-1:0] r1, input logic [RW-1:0] r2, input logic rn);
      @(negedge clk);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      iss_valid = iv; iss_rd = ird;
      raddr1 = r1; raddr2 = r2; rst_n = rn;
      #1;
      if (!rn) model_reset();
      compare();
      model_step(av, ard, ad, lv, lrd, ld, iv, ird, rn);
   endtask

   task automatic idle(input logic [RW-1:0] r1, input logic [RW-1:0] r2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1);
   endtask

   function automatic logic [RW-1:0] rand_rd();
      if ($urandom_range(0, 3) == 0) return '0;
      return RW'($urandom_range(1, RN - 1));
   endfunction

   initial begin
      int alu_pct;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(7, 9);
      chk("rst_wen", wen, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_ready", lsu_ready, 1);
      chk("rst_pending", wb_pending, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_busy2", busy2, 0);

      // ALU path and x0 discard
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("alu_wen", wen, 1);
      chk("alu_waddr", waddr, 5);
      chk("alu_wdata", wdata, 32'hDEADBEEF);
      idle(0, 0);
      chk("alu_x0_wen", wen, 0);
      chk("alu_x0_hold", waddr, 5);

      // ALU and LSU in the same cycle with empty FIFO
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 0, 0, 1);
      idle(0, 0);
      chk("cont_first", waddr, 3);
      chk("cont_first_wen", wen, 1);
      idle(0, 0);
      chk("cont_second", waddr, 7);
      chk("cont_second_data", wdata, 32'h77);
      chk("cont_second_wen", wen, 1);
      idle(0, 0);

      // Fill the FIFO behind a stalling ALU stream, then drain
      for (int i = 0; i < 4; i++)
         drive(1, 1, 32'h100 + i, 1, RW'(10 + i), 32'hA0000000 + i, 0, 0, 0, 0, 1);
      idle(0, 0);
      chk("full_ready", lsu_ready, 0);
      chk("full_pending", wb_pending, 1);
      for (int i = 0; i < 4; i++) begin
         idle(0, 0);
         chk("drain_wen", wen, 1);
         chk("drain_waddr", waddr, 10 + i);
         chk("drain_wdata", wdata, 32'hA0000000 + i);
         chk("drain_ready", lsu_ready, 1);
      end
      idle(0, 0);
      chk("drain_done", wb_pending, 0);

      // Scoreboard: set, re-issue on writeback, clear
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1);
      chk("sb_before", busy1, 0);
      drive(1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 0, 1);
      chk("sb_set", busy1, 1);
      chk("sb_x0", busy2, 0);
      drive(1, 9, 32'h98, 0, 0, 0, 0, 0, 9, 0, 1);
      chk("sb_wb_wen", wen, 1);
      chk("sb_reissue", busy1, 1);
      idle(9, 0);
      chk("sb_clear", busy1, 0);
      chk("sb_clear_wen", waddr, 9);

`ifdef WB_FWD_EN
      drive(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 4, 32'h45, 0, 0, 0, 0, 0, 4, 0, 1);
      chk("fwd_hit", fwd1, 1);
      chk("fwd_data", fwd_data1, 32'h44);
      idle(0, 4);
      chk("fwd_x0", fwd1, 0);
      chk("fwd_hit2", fwd2, 1);
`endif

      // Reset mid-stream with three entries buffered
      for (int i = 0; i < 3; i++)
         drive(1, 1, 32'h1, 1, RW'(21 + i), 32'hB0 + i, 1, 20, 20, 0, 1);
      idle(20, 0);
      chk("pre_rst_pending", wb_pending, 1);
      chk("pre_rst_busy", busy1, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 0);
      chk("mid_rst_wen", wen, 0);
      chk("mid_rst_pending", wb_pending, 0);
      idle(20, 21);
      chk("post_rst_wen", wen, 0);
      chk("post_rst_pending", wb_pending, 0);
      chk("post_rst_ready", lsu_ready, 1);
      chk("post_rst_busy1", busy1, 0);
      chk("post_rst_busy2", busy2, 0);

      // Randomized traffic
      alu_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) alu_pct = $urandom_range(10, 95);
         drive($urandom_range(0, 99) < alu_pct, rand_rd(), $urandom,
               $urandom_range(0, 99) < 60, rand_rd(), $urandom,
               $urandom_range(0, 99) < 50, rand_rd(),
               rand_rd(), rand_rd(), $urandom_range(0, 399) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
